// File: rtl/lram_arb_pkg.sv
// Shared types and default widths for the two-requester LRAM arbiter.
// Imported by lram_arbiter and lram_arb_tag_pipe.
package lram_arb_pkg;

  localparam int NUM_REQ     = 2;
  localparam int ID_W        = 1;
  localparam int LRAM_ADDR_W = 14;
  localparam int LRAM_DATA_W = 32;
  localparam int LRAM_BEN_W  = LRAM_DATA_W / 8;

  typedef struct packed {
    logic                   we;
    logic [LRAM_ADDR_W-1:0] addr;
    logic [LRAM_DATA_W-1:0] wdata;
    logic [LRAM_BEN_W-1:0]  ben;
  } lram_req_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } lram_tag_t;

  localparam lram_tag_t TAG_NONE = '{valid: 1'b0, id: 1'b0};

endpackage

// File: rtl/lram_arb_tag_pipe.sv
// Fixed-depth shift register of read tags; a tag leaves it in the cycle the
// matching LRAM read data is presented on mem_rd_data_i.
module lram_arb_tag_pipe
  import lram_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  lram_tag_t i_tag,
  output lram_tag_t o_tag
);

  lram_tag_t r_pipe [DEPTH];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= TAG_NONE;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/lram_arbiter.sv
// Two-requester round-robin arbiter in front of one registered LRAM port.
// Optional burst locking is compiled in with `define LRAM_ARB_LOCK_EN.
module lram_arbiter
  import lram_arb_pkg::*;
#(
  parameter int   ADDR_WIDTH = LRAM_ADDR_W,
  parameter int   DATA_WIDTH = LRAM_DATA_W,
  parameter int   BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int   RD_LATENCY = 2,
  parameter logic BYTE_POL   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_0_i,
  output logic                  req_ready_0_o,
  input  logic                  req_we_0_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_0_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_0_i,
  input  logic [BYTE_WIDTH-1:0] req_ben_0_i,
  output logic                  rsp_valid_0_o,
  output logic [DATA_WIDTH-1:0] rsp_data_0_o,
  input  logic                  req_valid_1_i,
  output logic                  req_ready_1_o,
  input  logic                  req_we_1_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_1_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_1_i,
  input  logic [BYTE_WIDTH-1:0] req_ben_1_i,
  output logic                  rsp_valid_1_o,
  output logic [DATA_WIDTH-1:0] rsp_data_1_o,
`ifdef LRAM_ARB_LOCK_EN
  input  logic                  req_lock_0_i,
  input  logic                  req_lock_1_i,
`endif
  output logic                  mem_clk_en_o,
  output logic                  mem_rdout_clken_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic [BYTE_WIDTH-1:0] mem_ben_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  logic [NUM_REQ-1:0]    w_valid;
  logic [NUM_REQ-1:0]    w_lock;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_we    [NUM_REQ];
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];
  logic [BYTE_WIDTH-1:0] w_ben   [NUM_REQ];
  logic                  w_accept;
  logic [ID_W-1:0]       w_grant_id;
  lram_tag_t             w_tag_in;
  lram_tag_t             w_tag_out;

  logic                  r_last_grant;
  logic                  r_clk_en;
  logic                  r_rdout_clken;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BYTE_WIDTH-1:0] r_ben;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data [NUM_REQ];

  assign w_valid    = {req_valid_1_i, req_valid_0_i};
  assign w_we[0]    = req_we_0_i;
  assign w_we[1]    = req_we_1_i;
  assign w_addr[0]  = req_addr_0_i;
  assign w_addr[1]  = req_addr_1_i;
  assign w_wdata[0] = req_wdata_0_i;
  assign w_wdata[1] = req_wdata_1_i;
  assign w_ben[0]   = req_ben_0_i;
  assign w_ben[1]   = req_ben_1_i;

`ifdef LRAM_ARB_LOCK_EN
  assign w_lock = {req_lock_1_i, req_lock_0_i};
`else
  assign w_lock = {NUM_REQ{1'b0}};
`endif

  // Grant selection; on a tie the last winner keeps the port only while locked.
  always_comb begin
    w_grant_id = 1'b0;
    w_ready    = {NUM_REQ{1'b0}};
    w_accept   = (|w_valid) & ~rst_i;
    case (w_valid)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11: begin
        if (w_lock[r_last_grant]) begin
          w_grant_id = r_last_grant;
        end else begin
          w_grant_id = ~r_last_grant;
        end
      end
      default: w_grant_id = 1'b0;
    endcase
    if (w_accept) begin
      w_ready[w_grant_id] = 1'b1;
    end else begin
      w_ready = {NUM_REQ{1'b0}};
    end
  end

  assign req_ready_0_o = w_ready[0];
  assign req_ready_1_o = w_ready[1];

  // Issue stage: the accepted request drives the LRAM port one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant  <= 1'b1;
      r_clk_en      <= 1'b0;
      r_rdout_clken <= 1'b0;
      r_wr_en       <= 1'b0;
      r_addr        <= {ADDR_WIDTH{1'b0}};
      r_wdata       <= {DATA_WIDTH{1'b0}};
      r_ben         <= {BYTE_WIDTH{~BYTE_POL}};
    end else begin
      r_rdout_clken <= 1'b1;
      r_clk_en      <= w_accept;
      if (w_accept) begin
        r_last_grant <= w_grant_id;
        r_wr_en      <= w_we[w_grant_id];
        r_addr       <= w_addr[w_grant_id];
        r_wdata      <= w_wdata[w_grant_id];
        r_ben        <= w_ben[w_grant_id];
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign mem_clk_en_o      = r_clk_en;
  assign mem_rdout_clken_o = r_rdout_clken;
  assign mem_wr_en_o       = r_wr_en;
  assign mem_addr_o        = r_addr;
  assign mem_wr_data_o     = r_wdata;
  assign mem_ben_o         = r_ben;

  assign w_tag_in.valid = w_accept & ~w_we[w_grant_id];
  assign w_tag_in.id    = w_grant_id;

  lram_arb_tag_pipe #(
    .DEPTH (1 + RD_LATENCY)
  ) u_tag_pipe (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Route returning read data to the requester named by the exiting tag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid   <= {NUM_REQ{1'b0}};
      r_rsp_data[0] <= {DATA_WIDTH{1'b0}};
      r_rsp_data[1] <= {DATA_WIDTH{1'b0}};
    end else begin
      r_rsp_valid <= {NUM_REQ{1'b0}};
      if (w_tag_out.valid) begin
        r_rsp_valid[w_tag_out.id] <= 1'b1;
        r_rsp_data[w_tag_out.id]  <= mem_rd_data_i;
      end
    end
  end

  assign rsp_valid_0_o = r_rsp_valid[0];
  assign rsp_valid_1_o = r_rsp_valid[1];
  assign rsp_data_0_o  = r_rsp_data[0];
  assign rsp_data_1_o  = r_rsp_data[1];

endmodule

// File: tb/tb_lram_arbiter.sv
// Directed bench for lram_arbiter with a behavioural two-stage LRAM model.
// Define LRAM_ARB_LOCK_EN for both bench and RTL to exercise burst locking.
module tb_lram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_0_i, req_valid_1_i;
  logic        req_ready_0_o, req_ready_1_o;
  logic        req_we_0_i, req_we_1_i;
  logic [13:0] req_addr_0_i, req_addr_1_i;
  logic [31:0] req_wdata_0_i, req_wdata_1_i;
  logic [3:0]  req_ben_0_i, req_ben_1_i;
  logic        rsp_valid_0_o, rsp_valid_1_o;
  logic [31:0] rsp_data_0_o, rsp_data_1_o;
  logic        req_lock_0_i, req_lock_1_i;
  logic        mem_clk_en_o, mem_rdout_clken_o, mem_wr_en_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [3:0]  mem_ben_o;
  logic [31:0] mem_rd_data_i;

  logic [31:0] mem [16384];
  logic [31:0] rd_stage;
  logic        pre_en;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  lram_arbiter dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_valid_0_i     (req_valid_0_i),
    .req_ready_0_o     (req_ready_0_o),
    .req_we_0_i        (req_we_0_i),
    .req_addr_0_i      (req_addr_0_i),
    .req_wdata_0_i     (req_wdata_0_i),
    .req_ben_0_i       (req_ben_0_i),
    .rsp_valid_0_o     (rsp_valid_0_o),
    .rsp_data_0_o      (rsp_data_0_o),
    .req_valid_1_i     (req_valid_1_i),
    .req_ready_1_o     (req_ready_1_o),
    .req_we_1_i        (req_we_1_i),
    .req_addr_1_i      (req_addr_1_i),
    .req_wdata_1_i     (req_wdata_1_i),
    .req_ben_1_i       (req_ben_1_i),
    .rsp_valid_1_o     (rsp_valid_1_o),
    .rsp_data_1_o      (rsp_data_1_o),
`ifdef LRAM_ARB_LOCK_EN
    .req_lock_0_i      (req_lock_0_i),
    .req_lock_1_i      (req_lock_1_i),
`endif
    .mem_clk_en_o      (mem_clk_en_o),
    .mem_rdout_clken_o (mem_rdout_clken_o),
    .mem_wr_en_o       (mem_wr_en_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wr_data_o     (mem_wr_data_o),
    .mem_ben_o         (mem_ben_o),
    .mem_rd_data_i     (mem_rd_data_i)
  );

  // LRAM model: array read at the address edge, then the output register.
  always @(posedge clk_i) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_clk_en_o) begin
      if (mem_wr_en_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_ben_o[b] == 1'b0) begin
            mem[mem_addr_o][8*b +: 8] <= mem_wr_data_o[8*b +: 8];
          end
        end
      end else begin
        rd_stage <= mem[mem_addr_o];
      end
    end
    if (mem_rdout_clken_o) begin
      mem_rd_data_i <= rd_stage;
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    pre_en = 1'b0; pre_addr = 14'h0; pre_data = 32'h0;
    req_valid_0_i = 1'b0; req_we_0_i = 1'b0; req_addr_0_i = 14'h0; req_wdata_0_i = 32'h0; req_ben_0_i = 4'h0;
    req_valid_1_i = 1'b0; req_we_1_i = 1'b0; req_addr_1_i = 14'h0; req_wdata_1_i = 32'h0; req_ben_1_i = 4'h0;
    req_lock_0_i = 1'b0; req_lock_1_i = 1'b0;
    tick();
    preload(14'h0010, 32'hDEADBEEF);
    preload(14'h0020, 32'h11110000);
    preload(14'h0040, 32'h22220000);
    preload(14'h0300, 32'h00000000);

    // Reset values
    chk("rst_ready0", 32'(req_ready_0_o), 32'h0);
    chk("rst_ready1", 32'(req_ready_1_o), 32'h0);
    chk("rst_rsp_valid", 32'({rsp_valid_1_o, rsp_valid_0_o}), 32'h0);
    chk("rst_rsp_data0", rsp_data_0_o, 32'h0);
    chk("rst_rsp_data1", rsp_data_1_o, 32'h0);
    chk("rst_clk_en", 32'(mem_clk_en_o), 32'h0);
    chk("rst_wr_en", 32'(mem_wr_en_o), 32'h0);
    chk("rst_addr", 32'(mem_addr_o), 32'h0);
    chk("rst_wdata", mem_wr_data_o, 32'h0);
    chk("rst_ben", 32'(mem_ben_o), 32'hF);
    chk("rst_rdout_clken", 32'(mem_rdout_clken_o), 32'h0);
    req_valid_0_i = 1'b1;
    #1;
    chk("rst_ready_gated", 32'(req_ready_0_o), 32'h0);
    req_valid_0_i = 1'b0;
    rst_i = 1'b0;
    tick();
    chk("rdout_clken_on", 32'(mem_rdout_clken_o), 32'h1);
    chk("idle_clk_en", 32'(mem_clk_en_o), 32'h0);

    // Round robin: both valid for six cycles, reads 0x20 / 0x40
    req_valid_0_i = 1'b1; req_we_0_i = 1'b0; req_addr_0_i = 14'h0020;
    req_valid_1_i = 1'b1; req_we_1_i = 1'b0; req_addr_1_i = 14'h0040;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready0", 32'(req_ready_0_o), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_ready1", 32'(req_ready_1_o), (i % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      chk("rr_clk_en", 32'(mem_clk_en_o), 32'h1);
      chk("rr_addr", 32'(mem_addr_o), (i % 2 == 0) ? 32'h20 : 32'h40);
      if (i >= 3) begin
        chk("rr_rsp_valid0", 32'(rsp_valid_0_o), ((i - 3) % 2 == 0) ? 32'h1 : 32'h0);
        chk("rr_rsp_valid1", 32'(rsp_valid_1_o), ((i - 3) % 2 == 1) ? 32'h1 : 32'h0);
      end
    end
    req_valid_0_i = 1'b0; req_valid_1_i = 1'b0;
    tick();
    chk("rr_tail_valid1", 32'(rsp_valid_1_o), 32'h1);
    chk("rr_tail_data1", rsp_data_1_o, 32'h22220000);
    tick();
    chk("rr_tail_valid0", 32'(rsp_valid_0_o), 32'h1);
    chk("rr_tail_data0", rsp_data_0_o, 32'h11110000);
    tick();
    tick();
    chk("rr_drained", 32'({rsp_valid_1_o, rsp_valid_0_o}), 32'h0);

    // Single read from requester 0
    req_valid_0_i = 1'b1; req_we_0_i = 1'b0; req_addr_0_i = 14'h0010;
    #1;
    chk("rd_ready0", 32'(req_ready_0_o), 32'h1);
    chk("rd_ready1", 32'(req_ready_1_o), 32'h0);
    tick();
    req_valid_0_i = 1'b0;
    chk("rd_clk_en", 32'(mem_clk_en_o), 32'h1);
    chk("rd_addr", 32'(mem_addr_o), 32'h10);
    chk("rd_wr_en", 32'(mem_wr_en_o), 32'h0);
    tick();
    chk("rd_idle_clk_en", 32'(mem_clk_en_o), 32'h0);
    chk("rd_early1", 32'({rsp_valid_1_o, rsp_valid_0_o}), 32'h0);
    tick();
    chk("rd_early2", 32'({rsp_valid_1_o, rsp_valid_0_o}), 32'h0);
    tick();
    chk("rd_rsp_valid0", 32'(rsp_valid_0_o), 32'h1);
    chk("rd_rsp_valid1", 32'(rsp_valid_1_o), 32'h0);
    chk("rd_rsp_data0", rsp_data_0_o, 32'hDEADBEEF);
    tick();
    chk("rd_pulse_end", 32'({rsp_valid_1_o, rsp_valid_0_o}), 32'h0);
    chk("rd_data_hold", rsp_data_0_o, 32'hDEADBEEF);

    // Write by requester 0 then read of same address by requester 1
    req_valid_0_i = 1'b1; req_we_0_i = 1'b1; req_addr_0_i = 14'h0200;
    req_wdata_0_i = 32'h12345678; req_ben_0_i = 4'h0;
    tick();
    chk("wr_wr_en", 32'(mem_wr_en_o), 32'h1);
    chk("wr_wdata", mem_wr_data_o, 32'h12345678);
    req_valid_0_i = 1'b0;
    req_valid_1_i = 1'b1; req_we_1_i = 1'b0; req_addr_1_i = 14'h0200;
    #1;
    chk("wr_rd_ready1", 32'(req_ready_1_o), 32'h1);
    tick();
    req_valid_1_i = 1'b0;
    chk("wr_rd_wr_en", 32'(mem_wr_en_o), 32'h0);
    tick();
    tick();
    tick();
    chk("wr_rd_valid1", 32'(rsp_valid_1_o), 32'h1);
    chk("wr_rd_valid0", 32'(rsp_valid_0_o), 32'h0);
    chk("wr_rd_data1", rsp_data_1_o, 32'h12345678);

    // Partial byte write then read back
    req_valid_0_i = 1'b1; req_we_0_i = 1'b1; req_addr_0_i = 14'h0300;
    req_wdata_0_i = 32'hAABBCCDD; req_ben_0_i = 4'b1110;
    tick();
    chk("bw_ben", 32'(mem_ben_o), 32'hE);
    req_we_0_i = 1'b0;
    tick();
    req_valid_0_i = 1'b0;
    tick();
    tick();
    tick();
    chk("bw_valid0", 32'(rsp_valid_0_o), 32'h1);
    chk("bw_data0", rsp_data_0_o, 32'h000000DD);

`ifdef LRAM_ARB_LOCK_EN
    // Requester 1 holds the port for four beats, then requester 0 wins
    req_valid_1_i = 1'b1; req_we_1_i = 1'b1; req_ben_1_i = 4'hF; req_lock_1_i = 1'b1;
    #1;
    chk("lk_first1", 32'(req_ready_1_o), 32'h1);
    tick();
    req_valid_0_i = 1'b1; req_we_0_i = 1'b1; req_ben_0_i = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lk_hold1", 32'(req_ready_1_o), 32'h1);
      chk("lk_hold0", 32'(req_ready_0_o), 32'h0);
      tick();
    end
    req_lock_1_i = 1'b0;
    #1;
    chk("lk_release0", 32'(req_ready_0_o), 32'h1);
    chk("lk_release1", 32'(req_ready_1_o), 32'h0);
    tick();
    req_valid_0_i = 1'b0; req_valid_1_i = 1'b0;
    tick();
`endif

    // Reset one cycle after two reads are accepted
    req_valid_0_i = 1'b1; req_we_0_i = 1'b0; req_addr_0_i = 14'h0010;
    req_valid_1_i = 1'b1; req_we_1_i = 1'b0; req_addr_1_i = 14'h0040;
    tick();
    tick();
    req_valid_0_i = 1'b0; req_valid_1_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    chk("mr_rsp_valid", 32'({rsp_valid_1_o, rsp_valid_0_o}), 32'h0);
    chk("mr_rsp_data0", rsp_data_0_o, 32'h0);
    chk("mr_rsp_data1", rsp_data_1_o, 32'h0);
    chk("mr_clk_en", 32'(mem_clk_en_o), 32'h0);
    chk("mr_addr", 32'(mem_addr_o), 32'h0);
    chk("mr_ben", 32'(mem_ben_o), 32'hF);
    chk("mr_rdout_clken", 32'(mem_rdout_clken_o), 32'h0);
    tick();
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_rsp", 32'({rsp_valid_1_o, rsp_valid_0_o}), 32'h0);
      chk("mr_no_issue", 32'(mem_clk_en_o), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
